// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen counter bit field.
package rggen_rtl_pkg;

   localparam int unsigned RGGEN_COUNTER_MAX_WIDTH = 64;

   typedef enum logic {
      RGGEN_COUNTER_WRAP     = 1'b0,
      RGGEN_COUNTER_SATURATE = 1'b1
   } rggen_counter_mode_e;

   typedef logic [RGGEN_COUNTER_MAX_WIDTH-1:0] rggen_counter_word_t;

   // One counting step: +1 for up only, -1 for down only, hold otherwise.
   // max_value is the all-ones pattern of the real counter width.
   function automatic rggen_counter_word_t rggen_counter_step(
      input rggen_counter_word_t value,
      input rggen_counter_word_t max_value,
      input logic                up,
      input logic                down,
      input rggen_counter_mode_e mode
   );
      rggen_counter_word_t result;
      result = value;
      if (up && !down) begin
         if (value == max_value) begin
            result = (mode == RGGEN_COUNTER_SATURATE) ? max_value : '0;
         end else begin
            result = value + rggen_counter_word_t'(1);
         end
      end else if (down && !up) begin
         if (value == '0) begin
            result = (mode == RGGEN_COUNTER_SATURATE) ? '0 : max_value;
         end else begin
            result = value - rggen_counter_word_t'(1);
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/rggen_bit_field_if.sv
// Bit-field access bundle between the register block and a bit-field leaf.
interface rggen_bit_field_if #(
   parameter int unsigned WIDTH = 16
);

   logic             write_access;
   logic             read_access;
   logic [WIDTH-1:0] write_data;
   logic [WIDTH-1:0] write_mask;
   logic [WIDTH-1:0] value;
   logic [WIDTH-1:0] read_data;

   modport master (
      output write_access,
      output read_access,
      output write_data,
      output write_mask,
      input  value,
      input  read_data
   );

   modport slave (
      input  write_access,
      input  read_access,
      input  write_data,
      input  write_mask,
      output value,
      output read_data
   );

endinterface

// File: rtl/rggen_counter_core.sv
// Counter register with step/limit logic.
// RGGEN_BIT_FIELD_COUNTER_OVERFLOW_EN adds the limit-hit output.
module rggen_counter_core
   import rggen_rtl_pkg::*;
#(
   parameter int unsigned         WIDTH         = 16,
   parameter logic [WIDTH-1:0]    INITIAL_VALUE = '0,
   parameter rggen_counter_mode_e MODE          = RGGEN_COUNTER_SATURATE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_value_i,
   input  logic             clear_i,
   input  logic             count_up_i,
   input  logic             count_down_i,
   output logic [WIDTH-1:0] count_o
`ifdef RGGEN_BIT_FIELD_COUNTER_OVERFLOW_EN
   ,
   output logic             limit_hit_c_o
`endif
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] base_c;
   logic [WIDTH-1:0] step_c;

   // Next count: a load replaces everything, otherwise step from count or the clear value.
   always_comb begin
      base_c  = count_q;
      step_c  = count_q;
      count_d = count_q;
      if (clear_i) begin
         base_c = INITIAL_VALUE;
      end
      step_c = WIDTH'(rggen_counter_step(rggen_counter_word_t'(base_c),
                                         rggen_counter_word_t'(ALL_ONES),
                                         count_up_i, count_down_i, MODE));
      if (load_i) begin
         count_d = load_value_i;
      end else begin
         count_d = step_c;
      end
   end

   // Counter state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= INITIAL_VALUE;
      end else begin
         count_q <= count_d;
      end
   end

`ifdef RGGEN_BIT_FIELD_COUNTER_OVERFLOW_EN
   // A hardware step landing on the limit in its own direction; loads mask it.
   always_comb begin
      limit_hit_c_o = 1'b0;
      if (!load_i) begin
         if (count_up_i && !count_down_i && (step_c == ALL_ONES)) begin
            limit_hit_c_o = 1'b1;
         end else if (count_down_i && !count_up_i && (step_c == '0)) begin
            limit_hit_c_o = 1'b1;
         end
      end
   end
`endif

   assign count_o = count_q;

endmodule

// File: rtl/rggen_bit_field_counter.sv
// Hardware event counter bit field: software masked write, optional clear-on-read.
// RGGEN_BIT_FIELD_COUNTER_OVERFLOW_EN adds the sticky o_overflow flag.
module rggen_bit_field_counter
   import rggen_rtl_pkg::*;
#(
   parameter int unsigned      WIDTH         = 16,
   parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
   parameter bit               SATURATE      = 1'b1,
   parameter bit               CLEAR_ON_READ = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   rggen_bit_field_if.slave bit_field_if,
   input  logic             i_count_up,
   input  logic             i_count_down,
   output logic [WIDTH-1:0] o_value
`ifdef RGGEN_BIT_FIELD_COUNTER_OVERFLOW_EN
   ,
   output logic             o_overflow
`endif
);

   localparam rggen_counter_mode_e MODE =
      SATURATE ? RGGEN_COUNTER_SATURATE : RGGEN_COUNTER_WRAP;

   logic             write_c;
   logic             read_c;
   logic [WIDTH-1:0] write_data_c;
   logic [WIDTH-1:0] write_mask_c;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] merged_c;
   logic             clear_c;

   assign write_c      = bit_field_if.write_access;
   assign read_c       = bit_field_if.read_access;
   assign write_data_c = bit_field_if.write_data;
   assign write_mask_c = bit_field_if.write_mask;

   // Software write merge and clear-on-read decision; a write always wins.
   always_comb begin
      merged_c = (count & ~write_mask_c) | (write_data_c & write_mask_c);
      clear_c  = 1'b0;
      if (CLEAR_ON_READ && read_c && !write_c) begin
         clear_c = 1'b1;
      end
   end

`ifdef RGGEN_BIT_FIELD_COUNTER_OVERFLOW_EN
   logic limit_hit_c;
   logic overflow_q;
   logic overflow_d;
`endif

   rggen_counter_core #(
      .WIDTH         (WIDTH),
      .INITIAL_VALUE (INITIAL_VALUE),
      .MODE          (MODE)
   ) u_core (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_i        (write_c),
      .load_value_i  (merged_c),
      .clear_i       (clear_c),
      .count_up_i    (i_count_up),
      .count_down_i  (i_count_down),
      .count_o       (count)
`ifdef RGGEN_BIT_FIELD_COUNTER_OVERFLOW_EN
      ,
      .limit_hit_c_o (limit_hit_c)
`endif
   );

`ifdef RGGEN_BIT_FIELD_COUNTER_OVERFLOW_EN
   // Sticky flag: a limit hit sets it ahead of any clear in the same cycle.
   always_comb begin
      overflow_d = overflow_q;
      if (limit_hit_c) begin
         overflow_d = 1'b1;
      end else if ((write_c && (|write_mask_c)) || clear_c) begin
         overflow_d = 1'b0;
      end
   end

   // Overflow flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign o_overflow = overflow_q;
`endif

   assign o_value                = count;
   assign bit_field_if.value     = count;
   assign bit_field_if.read_data = count;

endmodule
